// File: rtl/imm_prefix_gen_if.sv
// Decode-stage immediate bus: instruction beat in, registered immediate out.
// The master side drives the instruction beat and out_ready; the slave side is the generator.
interface imm_prefix_gen_if #(
  parameter int unsigned IMM_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      instruction;
  logic [2:0]       imm_src;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [IMM_W-1:0] imm_out;
  logic             prefixed;
  logic             illegal;

  modport master (
    output in_valid, instruction, imm_src, flush, out_ready,
    input  in_ready, out_valid, imm_out, prefixed, illegal
  );

  modport slave (
    input  in_valid, instruction, imm_src, flush, out_ready,
    output in_ready, out_valid, imm_out, prefixed, illegal
  );
endinterface

// File: rtl/imm_prefix_gen.sv
// Registered immediate generator with IMMX prefix support and a one-deep
// valid/ready output register for the 16-bit decode stage.
module imm_prefix_gen #(
  parameter int unsigned IMM_W     = 16,
  parameter logic [3:0]  PREFIX_OP = 4'b1111
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_prefix_gen_if.slave    bus
);

  logic             r_out_valid;
  logic             r_prefixed;
  logic             r_illegal;
  logic [IMM_W-1:0] r_imm;
  logic             r_pfx_valid;
  logic [11:0]      r_pfx;

  logic             w_in_ready;
  logic             w_acc;
  logic             w_is_pfx;
  logic [3:0]       w_op;
  logic [7:0]       w_f;
  logic [3:0]       w_wf;
  logic [5:0]       w_top;
  logic [2:0]       w_msb;
  logic             w_sgn;
  logic             w_pfx_ok;
  logic             w_upper_mode;
  logic             w_ill;
  logic             w_pre;
  logic [IMM_W-1:0] w_full;
  logic [IMM_W-1:0] w_upper;
  logic [IMM_W-1:0] w_imm;

  assign w_op       = bus.instruction[15:12];
  assign w_is_pfx   = (w_op == PREFIX_OP);
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_acc      = bus.in_valid && w_in_ready;

  // Field select and extension kind per immediate mode.
  always_comb begin
    w_f          = '0;
    w_wf         = '0;
    w_sgn        = 1'b0;
    w_pfx_ok     = 1'b0;
    w_upper_mode = 1'b0;
    w_ill        = 1'b0;
    unique case (bus.imm_src)
      3'b000: begin
        if (w_op == 4'b1010) begin
          w_f = bus.instruction[8:1];  w_wf = 4'd8; w_pfx_ok = 1'b1;
        end else if (w_op == 4'b1101) begin
          w_f = bus.instruction[11:4]; w_wf = 4'd8; w_pfx_ok = 1'b1;
        end else begin
          w_ill = 1'b1;
        end
      end
      3'b001: begin w_f = {2'b00, bus.instruction[5:0]};  w_wf = 4'd6; w_pfx_ok = 1'b1; end
      3'b010: begin w_f = {5'b0, bus.instruction[5:3]};   w_wf = 4'd3; w_pfx_ok = 1'b1; end
      3'b011: begin w_f = {3'b0, bus.instruction[5:1]};   w_wf = 4'd5; w_pfx_ok = 1'b1; w_sgn = 1'b1; end
      3'b100: begin w_f = {2'b00, bus.instruction[5:0]};  w_wf = 4'd6; w_pfx_ok = 1'b1; w_sgn = 1'b1; end
      3'b101: w_upper_mode = 1'b1;
      default: w_ill = 1'b1;
    endcase
  end

  // {pfx, F} is built wide and truncated to IMM_W; sign fill starts just above the concatenation.
  always_comb begin
    w_top   = 6'd12 + {2'b00, w_wf};
    w_msb   = w_wf[2:0] - 3'd1;
    w_pre   = 1'b0;
    w_upper = '0;
    w_upper[IMM_W-1 -: 8] = bus.instruction[11:4];
    if (w_pfx_ok && r_pfx_valid) begin
      w_pre  = 1'b1;
      w_full = IMM_W'(({32'b0, r_pfx} << w_wf) | {36'b0, w_f});
      if (w_sgn && r_pfx[11])
        w_full = w_full | IMM_W'({44{1'b1}} << w_top);
    end else begin
      w_full = IMM_W'({36'b0, w_f});
      if (w_sgn && w_f[w_msb])
        w_full = w_full | IMM_W'({44{1'b1}} << w_wf);
    end
    w_imm = w_upper_mode ? w_upper : w_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_prefixed  <= 1'b0;
      r_illegal   <= 1'b0;
      r_imm       <= '0;
      r_pfx_valid <= 1'b0;
      r_pfx       <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
      r_pfx_valid <= 1'b0;
    end else if (w_acc) begin
      if (w_is_pfx) begin
        // Accept implies the old result (if any) was popped this edge.
        r_pfx       <= bus.instruction[11:0];
        r_pfx_valid <= 1'b1;
        r_out_valid <= 1'b0;
      end else begin
        r_imm       <= w_imm;
        r_prefixed  <= w_pre;
        r_illegal   <= w_ill;
        r_out_valid <= 1'b1;
        r_pfx_valid <= 1'b0;
      end
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.imm_out   = r_imm;
  assign bus.prefixed  = r_prefixed;
  assign bus.illegal   = r_illegal;

endmodule
